// File: rtl/ds_pkg.sv
// Shared types and helpers for the stream_downscaler block: FSM state, Q-format unity step,
// step clamp and accumulator sizing.
package ds_pkg;

  typedef enum logic {
    DS_IDLE = 1'b0,
    DS_RUN  = 1'b1
  } ds_state_t;

  localparam int DS_FRAC = 8;
  localparam int ONE_Q   = 1 << DS_FRAC;

  // Wide enough for the largest coordinate plus one full step, so the target never wraps.
  function automatic int ds_acc_width(input int step_w, input int src_w, input int src_h);
    return step_w + $clog2((src_w > src_h) ? src_w : src_h);
  endfunction

  // Steps below 1.0 would request upscaling; they are treated as 1.0.
  function automatic logic [31:0] ds_clamp_step(input logic [31:0] step, input int frac);
    logic [31:0] one;
    one = 32'd1 << frac;
    return (step < one) ? one : step;
  endfunction

endpackage

// File: rtl/ds_coord_stepper.sv
// One axis of the downscaler: source coordinate counter plus fixed-point target accumulator.
// i_restart makes the current beat count as coordinate 0 with a zero target.
module ds_coord_stepper
  import ds_pkg::*;
#(
  parameter int LIMIT  = 160,
  parameter int STEP_W = 16,
  parameter int FRAC   = DS_FRAC,
  parameter int ACC_W  = ds_acc_width(16, 160, 120)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_beat,
  input  logic              i_restart,
  input  logic              i_adv,
  input  logic              i_add,
  input  logic              i_clr,
  input  logic [STEP_W-1:0] i_step,
  output logic              o_match,
  output logic              o_wrap,
  output logic              o_last
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam int INT_W = ACC_W - FRAC;

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] w_cnt;
  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_sum;

  assign w_cnt = i_restart ? '0 : r_cnt;
  assign w_acc = i_restart ? '0 : r_acc;
  assign w_sum = w_acc + ACC_W'(i_step);

  assign o_match = (INT_W'(w_cnt) == w_acc[ACC_W-1:FRAC]);
  assign o_wrap  = (w_cnt == CNT_W'(LIMIT - 1));
  assign o_last  = (w_sum[ACC_W-1:FRAC] > INT_W'(LIMIT - 1));

  // NOTE: non-blocking assignments make every register update independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_beat) begin
      if (i_adv) r_cnt <= o_wrap ? '0 : w_cnt + CNT_W'(1);
      else       r_cnt <= w_cnt;

      if (i_clr)      r_acc <= '0;
      else if (i_add) r_acc <= w_sum;
      else            r_acc <= w_acc;
    end
  end

endmodule

// File: rtl/stream_downscaler.sv
// Streaming nearest-neighbour downscaler with a per-frame fractional step (Q.FRAC).
// Define DS_SKID_EN for a 2-entry output skid buffer; otherwise a single output register is used.
module stream_downscaler
  import ds_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int STEP_W = 16,
  parameter int FRAC   = DS_FRAC
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [STEP_W-1:0] i_cfg_step,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PIX_W-1:0]  i_in_pixel,
  input  logic              i_in_sof,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [PIX_W-1:0]  o_out_pixel,
  output logic              o_out_sof,
  output logic              o_out_eol,
  output logic              o_out_eof,
  output logic              o_busy,
  output logic              o_sof_err
);

  localparam int ACC_W = ds_acc_width(STEP_W, SRC_W, SRC_H);

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic             sof;
    logic             eol;
    logic             eof;
  } beat_t;

  ds_state_t         r_state;
  logic              r_busy;
  logic              r_sof_err;
  logic [STEP_W-1:0] r_step;

  logic [STEP_W-1:0] w_step_cfg;
  logic [STEP_W-1:0] w_step;
  logic              w_in_fire;
  logic              w_proc;
  logic              w_keep;
  logic              w_x_match, w_x_wrap, w_x_last;
  logic              w_y_match, w_y_wrap, w_y_last;
  beat_t             w_beat;
  beat_t             w_head;

  assign w_step_cfg = STEP_W'(ds_clamp_step(32'(i_cfg_step), FRAC));
  // The sof beat itself is processed with the freshly latched step.
  assign w_step     = i_in_sof ? w_step_cfg : r_step;
  assign w_in_fire  = i_in_valid && o_in_ready;
  assign w_proc     = w_in_fire && (i_in_sof || (r_state == DS_RUN));
  assign w_keep     = w_proc && w_x_match && w_y_match;
  assign w_beat     = {i_in_pixel, i_in_sof, w_x_last, w_x_last && w_y_last};

  ds_coord_stepper #(
    .LIMIT (SRC_W),
    .STEP_W(STEP_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_x_stepper (
    .i_clk    (i_clock),
    .i_rst_n  (i_reset_n),
    .i_beat   (w_proc),
    .i_restart(i_in_sof),
    .i_adv    (1'b1),
    .i_add    (w_keep),
    .i_clr    (w_x_wrap),
    .i_step   (w_step),
    .o_match  (w_x_match),
    .o_wrap   (w_x_wrap),
    .o_last   (w_x_last)
  );

  ds_coord_stepper #(
    .LIMIT (SRC_H),
    .STEP_W(STEP_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_y_stepper (
    .i_clk    (i_clock),
    .i_rst_n  (i_reset_n),
    .i_beat   (w_proc),
    .i_restart(i_in_sof),
    .i_adv    (w_x_wrap),
    .i_add    (w_x_wrap && w_y_match),
    .i_clr    (1'b0),
    .i_step   (w_step),
    .o_match  (w_y_match),
    .o_wrap   (w_y_wrap),
    .o_last   (w_y_last)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state   <= DS_IDLE;
      r_busy    <= 1'b0;
      r_sof_err <= 1'b0;
      r_step    <= '0;
    end else begin
      r_sof_err <= w_in_fire && i_in_sof && (r_state == DS_RUN);
      if (w_in_fire && i_in_sof) r_step <= w_step_cfg;
      if (w_proc && w_x_wrap && w_y_wrap) begin
        r_state <= DS_IDLE;
        r_busy  <= 1'b0;
      end else if (w_proc) begin
        r_state <= DS_RUN;
        r_busy  <= 1'b1;
      end
    end
  end

`ifdef DS_SKID_EN
  beat_t      r_q0;
  beat_t      r_q1;
  logic [1:0] r_cnt;
  logic       w_pop;

  assign w_pop       = (r_cnt != 2'd0) && i_out_ready;
  assign o_in_ready  = (r_cnt != 2'd2);
  assign o_out_valid = (r_cnt != 2'd0);
  assign w_head      = r_q0;

  // NOTE: the skid entries are plain registers, so they are reset along with the occupancy.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_keep, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= w_beat;
          else               r_q1 <= w_beat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= w_beat;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= w_beat;
          end
        end
        default: ;
      endcase
    end
  end
`else
  beat_t r_q0;
  logic  r_valid;

  assign o_in_ready  = !r_valid || i_out_ready;
  assign o_out_valid = r_valid;
  assign w_head      = r_q0;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_q0    <= '0;
      r_valid <= 1'b0;
    end else if (w_keep) begin
      r_q0    <= w_beat;
      r_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign o_out_pixel = w_head.pixel;
  assign o_out_sof   = w_head.sof;
  assign o_out_eol   = w_head.eol;
  assign o_out_eof   = w_head.eof;
  assign o_busy      = r_busy;
  assign o_sof_err   = r_sof_err;

endmodule

// File: tb/tb_stream_downscaler.sv
// Scoreboard bench for stream_downscaler: a coordinate-table model predicts kept beats at
// acceptance; DUT output beats are popped and compared. Honours DS_SKID_EN when defined.
`timescale 1ns/1ps
module tb_stream_downscaler;
  import ds_pkg::*;

  localparam int SRC_W  = 160;
  localparam int SRC_H  = 120;
  localparam int PIX_W  = 8;
  localparam int STEP_W = 16;
  localparam int FULL   = SRC_W * SRC_H;

  logic              clk = 1'b0;
  logic              i_reset_n;
  logic [STEP_W-1:0] i_cfg_step;
  logic              i_in_valid;
  logic              o_in_ready;
  logic [PIX_W-1:0]  i_in_pixel;
  logic              i_in_sof;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [PIX_W-1:0]  o_out_pixel;
  logic              o_out_sof;
  logic              o_out_eol;
  logic              o_out_eof;
  logic              o_busy;
  logic              o_sof_err;

  always #5 clk = ~clk;

  stream_downscaler #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .PIX_W (PIX_W),
    .STEP_W(STEP_W)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (i_reset_n),
    .i_cfg_step (i_cfg_step),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_pixel (i_in_pixel),
    .i_in_sof   (i_in_sof),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_out_pixel(o_out_pixel),
    .o_out_sof  (o_out_sof),
    .o_out_eol  (o_out_eol),
    .o_out_eof  (o_out_eof),
    .o_busy     (o_busy),
    .o_sof_err  (o_sof_err)
  );

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic             sof;
    logic             eol;
    logic             eof;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bit   xk[SRC_W];
  bit   xl[SRC_W];
  bit   yk[SRC_H];
  bit   yl[SRC_H];
  bit   m_run;
  int   m_col;
  int   m_row;
  int   m_step;
  logic exp_busy;
  logic exp_sof_err;
  logic nxt_sof_err;
  exp_t held;
  bit   held_v;
  bit   rnd_rdy;
  int   n_out;
  int   n_eol;
  int   n_eof;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Kept coordinates are the integer parts of i*step, computed directly from the product.
  task automatic build_tables(input int s);
    for (int c = 0; c < SRC_W; c++) begin xk[c] = 0; xl[c] = 0; end
    for (int r = 0; r < SRC_H; r++) begin yk[r] = 0; yl[r] = 0; end
    for (int i = 0; ((i * s) >> DS_FRAC) < SRC_W; i++) begin
      xk[(i * s) >> DS_FRAC] = 1;
      if ((((i + 1) * s) >> DS_FRAC) > SRC_W - 1) xl[(i * s) >> DS_FRAC] = 1;
    end
    for (int i = 0; ((i * s) >> DS_FRAC) < SRC_H; i++) begin
      yk[(i * s) >> DS_FRAC] = 1;
      if ((((i + 1) * s) >> DS_FRAC) > SRC_H - 1) yl[(i * s) >> DS_FRAC] = 1;
    end
  endtask

  task automatic model_accept(input logic [PIX_W-1:0] pix, input logic sof, input logic [STEP_W-1:0] cfg);
    exp_t e;
    if (sof) begin
      if (m_run) nxt_sof_err = 1'b1;
      m_run  = 1;
      m_step = (int'(cfg) < ONE_Q) ? ONE_Q : int'(cfg);
      build_tables(m_step);
      m_col = 0;
      m_row = 0;
    end
    if (m_run) begin
      if (xk[m_col] && yk[m_row]) begin
        e.pixel = pix;
        e.sof   = sof;
        e.eol   = xl[m_col];
        e.eof   = xl[m_col] && yl[m_row];
        sb.push_back(e);
      end
      if (m_col == SRC_W - 1) begin
        m_col = 0;
        if (m_row == SRC_H - 1) begin
          m_row = 0;
          m_run = 0;
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven; evaluates the coming rising edge.
  task automatic tick(output bit acc);
    exp_t got;
    exp_t e;
    bit   in_fire;
    bit   out_fire;
    #1;
    got = {o_out_pixel, o_out_sof, o_out_eol, o_out_eof};
    check("busy", 32'(o_busy), 32'(exp_busy));
    check("sof_err", 32'(o_sof_err), 32'(exp_sof_err));
    check("out_valid", 32'(o_out_valid), 32'(sb.size() != 0));
    if (held_v) check("stall_stable", 32'(got), 32'(held));
`ifdef DS_SKID_EN
    if (!o_in_ready) check("skid_ready", 32'(sb.size()), 32'd2);
`endif
    in_fire     = i_in_valid && o_in_ready;
    out_fire    = o_out_valid && i_out_ready;
    nxt_sof_err = 1'b0;
    if (out_fire && sb.size() != 0) begin
      e = sb.pop_front();
      check("beat", 32'(got), 32'(e));
      n_out++;
      n_eol += int'(got.eol);
      n_eof += int'(got.eof);
    end
    if (in_fire) model_accept(i_in_pixel, i_in_sof, i_cfg_step);
    held_v      = o_out_valid && !i_out_ready;
    held        = got;
    exp_sof_err = nxt_sof_err;
    exp_busy    = m_run;
    @(posedge clk);
    @(negedge clk);
    acc = in_fire;
  endtask

  task automatic send_beat(input logic [PIX_W-1:0] pix, input logic sof, input logic [STEP_W-1:0] cfg);
    bit acc;
    int guard;
    acc   = 0;
    guard = 0;
    while (!acc && guard < 64) begin
      i_in_valid  = 1'b1;
      i_in_pixel  = pix;
      i_in_sof    = sof;
      i_cfg_step  = cfg;
      i_out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(acc);
      guard++;
    end
    if (!acc) check("in_ready_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input logic [STEP_W-1:0] step, input int n, input bit rnd, input bit rand_pix);
    rnd_rdy = rnd;
    n_out   = 0;
    n_eol   = 0;
    n_eof   = 0;
    for (int idx = 0; idx < n; idx++) begin
      int               x;
      int               y;
      logic [PIX_W-1:0] pix;
      x   = idx % SRC_W;
      y   = idx / SRC_W;
      pix = rand_pix ? PIX_W'($urandom) : PIX_W'(x + y);
      send_beat(pix, idx == 0, (idx == 0) ? step : STEP_W'($urandom));
    end
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard      = 0;
    i_in_valid = 1'b0;
    i_in_sof   = 1'b0;
    while (sb.size() != 0 && guard < 200) begin
      i_out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(acc);
      guard++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    i_reset_n   = 1'b0;
    i_cfg_step  = '0;
    i_in_valid  = 1'b0;
    i_in_pixel  = '0;
    i_in_sof    = 1'b0;
    i_out_ready = 1'b1;
    m_run       = 0;
    m_col       = 0;
    m_row       = 0;
    exp_busy    = 1'b0;
    exp_sof_err = 1'b0;
    held_v      = 0;
    rnd_rdy     = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(o_in_ready), 32'd1);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_sof_err", 32'(o_sof_err), 32'd0);
    check("rst_out_flags", 32'({o_out_pixel, o_out_sof, o_out_eol, o_out_eof}), 32'd0);
    i_reset_n = 1'b1;
    @(negedge clk);

    // Beats without sof while idle are dropped.
    for (int k = 0; k < 3; k++) send_beat(8'hA5, 1'b0, 16'h0140);

    // 1.25 step, full rate: 128x96.
    send_frame(16'h0140, FULL, 0, 0);
    drain();
    check("A_beats", 32'(n_out), 32'd12288);
    check("A_eol", 32'(n_eol), 32'd96);
    check("A_eof", 32'(n_eof), 32'd1);

    // Step below 1.0 clamps to identity; frame left running.
    send_frame(16'h0080, 10 * SRC_W, 0, 1);
    drain();
    check("C_beats", 32'(n_out), 32'(10 * SRC_W));

    // Identity, restarted mid-frame by the next sof at (40,10).
    send_frame(16'h0100, 10 * SRC_W + 40, 0, 1);
    drain();
    check("B_beats", 32'(n_out), 32'(10 * SRC_W + 40));

    // 1.25 step with 50% downstream backpressure.
    send_frame(16'h0140, FULL, 1, 0);
    drain();
    check("D_beats", 32'(n_out), 32'd12288);
    check("D_eol", 32'(n_eol), 32'd96);
    check("D_eof", 32'(n_eof), 32'd1);

    // Reset for one cycle in the middle of a 2.0-step frame.
    send_frame(16'h0200, 2000, 1, 1);
    i_reset_n  = 1'b0;
    i_in_valid = 1'b1;
    i_in_sof   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", 32'(o_out_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    sb.delete();
    m_run       = 0;
    exp_busy    = 1'b0;
    exp_sof_err = 1'b0;
    held_v      = 0;
    i_reset_n   = 1'b1;
    i_in_valid  = 1'b0;
    @(negedge clk);
    tick(acc);

    // 2.0 step after reset: 80x60, even rows and columns.
    send_frame(16'h0200, FULL, 0, 0);
    drain();
    check("F_beats", 32'(n_out), 32'd4800);
    check("F_eol", 32'(n_eol), 32'd60);
    check("F_eof", 32'(n_eof), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
